conv_window_gen: RTL and testbench

Streaming 3x3 window generator feeding the 16-lane MAC array. Accepts a raster-order pixel stream (16-bit Q2.14), builds 3x3 windows with two line buffers, and packs NUM_MACS consecutive windows into one bundle. The bundle is presented with a valid/ready handshake that matches the MAC array's `valid_i`/`ready_o` pair. This block is the producer on that interface.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/conv_window_gen_line_buf.sv | 38 +++
 rtl/conv_window_gen.sv | 186 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front-end: element/window widths and
// the window generator's FILL/HOLD state encoding.
package cnn_pkg;

  localparam int DEF_DEC_BITS      = 2;
  localparam int DEF_MANTISSA_BITS = 14;
  localparam int ELEM_W            = DEF_DEC_BITS + DEF_MANTISSA_BITS;
  localparam int WIN_ELEMS         = 9;
  localparam int WIN_W             = WIN_ELEMS * ELEM_W;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } win_state_e;

endpackage

// File: rtl/conv_window_gen_line_buf.sv
// line_buf: one image row of pixels, single port, read-before-write at the
// shared address so the previous row's pixel is visible while it is replaced.
module line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = ELEM_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign rd_data = mem_q[addr];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[addr] = wr_data;
  end

  // NOTE: this array is small and flop-based, so it is cleared on reset;
  // a RAM macro would instead rely on row>=2 gating to hide stale contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixels -> 3x3 windows packed NUM_MACS per bundle,
// handed to the MAC array over valid/ready. `WINGEN_STATS_EN adds bundle_cnt_o.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int DEC_BITS      = 2,
  parameter int MANTISSA_BITS = 14,
  parameter int NUM_MACS      = 16,
  parameter int IMG_W         = 8,
  parameter int IMG_H         = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [DEC_BITS+MANTISSA_BITS-1:0]                   px_i,
  input  logic                                                px_valid_i,
  output logic                                                px_ready_o,
  output logic [NUM_MACS-1:0][WIN_ELEMS*(DEC_BITS+MANTISSA_BITS)-1:0] ifmap_chunk_o,
  output logic [NUM_MACS-1:0]                                 win_mask_o,
  output logic                                                win_last_o,
  output logic                                                win_valid_o,
  input  logic                                                win_ready_i
`ifdef WINGEN_STATS_EN
  ,
  output logic [15:0]                                         bundle_cnt_o
`endif
);

  localparam int EW     = DEC_BITS + MANTISSA_BITS;
  localparam int WW     = WIN_ELEMS * EW;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int LANE_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;

  // [r][c]: r=0 is the oldest (top) row, c=0 the oldest (left) column.
  typedef logic [2:0][2:0][EW-1:0] win_t;

  win_state_e                  state_q, state_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  win_t                        win_q, win_d, win_next;
  logic [NUM_MACS-1:0][WW-1:0] chunk_q, chunk_d;
  logic [NUM_MACS-1:0]         mask_q, mask_d;
  logic                        last_q, last_d;
  logic                        px_ready_q, px_ready_d;
  logic                        win_valid_q, win_valid_d;

  logic [EW-1:0] lb1_rd, lb2_rd;
  logic          px_fire, at_last_col, at_last_row, frame_end, win_emit;

  assign px_fire     = px_valid_i && px_ready_q;
  assign at_last_col = (col_q == COL_W'(IMG_W - 1));
  assign at_last_row = (row_q == ROW_W'(IMG_H - 1));
  assign frame_end   = at_last_col && at_last_row;
  assign win_emit    = px_fire && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // lb1 holds row-1; its displaced pixel becomes row-2 in lb2.
  line_buf #(.DEPTH(IMG_W), .DATA_W(EW)) u_lb1 (
    .clk     (clk),
    .rst     (rst),
    .we      (px_fire),
    .addr    (col_q),
    .wr_data (px_i),
    .rd_data (lb1_rd)
  );

  line_buf #(.DEPTH(IMG_W), .DATA_W(EW)) u_lb2 (
    .clk     (clk),
    .rst     (rst),
    .we      (px_fire),
    .addr    (col_q),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  // NOTE: every variable gets a default at the top of the block with blocking
  // assignments, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    lane_d      = lane_q;
    win_d       = win_q;
    chunk_d     = chunk_q;
    mask_d      = mask_q;
    last_d      = last_q;
    px_ready_d  = px_ready_q;
    win_valid_d = win_valid_q;

    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = win_q[r][1];
      win_next[r][1] = win_q[r][2];
    end
    win_next[0][2] = lb2_rd;
    win_next[1][2] = lb1_rd;
    win_next[2][2] = px_i;

    case (state_q)
      FILL: begin
        if (px_fire) begin
          win_d = win_next;
          col_d = at_last_col ? '0 : col_q + COL_W'(1);
          if (at_last_col) row_d = at_last_row ? '0 : row_q + ROW_W'(1);

          if (win_emit) begin
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++)
                chunk_d[lane_q][(r*3+c)*EW +: EW] = win_next[r][c];
            mask_d[lane_q] = 1'b1;
            lane_d         = lane_q + LANE_W'(1);
            if (lane_q == LANE_W'(NUM_MACS - 1) || frame_end) begin
              state_d     = HOLD;
              px_ready_d  = 1'b0;
              win_valid_d = 1'b1;
              last_d      = frame_end;
            end
          end
        end
      end
      HOLD: begin
        if (win_ready_i) begin
          state_d     = FILL;
          px_ready_d  = 1'b1;
          win_valid_d = 1'b0;
          chunk_d     = '0;
          mask_d      = '0;
          last_d      = 1'b0;
          lane_d      = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      lane_q      <= '0;
      win_q       <= '0;
      chunk_q     <= '0;
      mask_q      <= '0;
      last_q      <= 1'b0;
      px_ready_q  <= 1'b1;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      win_q       <= win_d;
      chunk_q     <= chunk_d;
      mask_q      <= mask_d;
      last_q      <= last_d;
      px_ready_q  <= px_ready_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign px_ready_o    = px_ready_q;
  assign win_valid_o   = win_valid_q;
  assign ifmap_chunk_o = chunk_q;
  assign win_mask_o    = mask_q;
  assign win_last_o    = last_q;

`ifdef WINGEN_STATS_EN
  logic [15:0] bundle_cnt_q, bundle_cnt_d;

  always_comb begin
    bundle_cnt_d = bundle_cnt_q;
    if (win_valid_q && win_ready_i && (bundle_cnt_q != 16'hFFFF))
      bundle_cnt_d = bundle_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bundle_cnt_q <= '0;
    else      bundle_cnt_q <= bundle_cnt_d;
  end

  assign bundle_cnt_o = bundle_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: directed ramp frames plus random
// frames compared against a window/bundle model built from raster coordinates.
module tb_conv_window_gen;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NM   = 16;
  localparam int EW   = 16;
  localparam int WW   = 9 * EW;
  localparam int NPIX = W * H;
  localparam int WPR  = W - 2;
  localparam int NWIN = (W - 2) * (H - 2);
  localparam int NBUN = (NWIN + NM - 1) / NM;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [EW-1:0]       px_i = '0;
  logic                px_valid_i = 1'b0;
  logic                px_ready_o;
  logic [NM-1:0][WW-1:0] ifmap_chunk_o;
  logic [NM-1:0]       win_mask_o;
  logic                win_last_o;
  logic                win_valid_o;
  logic                win_ready_i = 1'b0;
`ifdef WINGEN_STATS_EN
  logic [15:0]         bundle_cnt_o;
`endif

  conv_window_gen #(
    .DEC_BITS(2), .MANTISSA_BITS(14), .NUM_MACS(NM), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .px_i          (px_i),
    .px_valid_i    (px_valid_i),
    .px_ready_o    (px_ready_o),
    .ifmap_chunk_o (ifmap_chunk_o),
    .win_mask_o    (win_mask_o),
    .win_last_o    (win_last_o),
    .win_valid_o   (win_valid_o),
    .win_ready_i   (win_ready_i)
`ifdef WINGEN_STATS_EN
    ,
    .bundle_cnt_o  (bundle_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NM-1:0][WW-1:0] data;
    logic [NM-1:0]         mask;
    logic                  last;
  } bundle_t;

  logic [EW-1:0] frames [2][NPIX];
  int lane0_ref [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  int lane3_ref [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

  // Window n of a frame has its bottom-right pixel at row 2+n/(W-2), col 2+n%(W-2).
  function automatic bundle_t model_bundle(int f, int b);
    bundle_t m = '0;
    for (int j = 0; j < NM; j++) begin
      int n;
      int br;
      int bc;
      n = b * NM + j;
      if (n < NWIN) begin
        br = 2 + n / WPR;
        bc = 2 + n % WPR;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            m.data[j][(r*3+c)*EW +: EW] = frames[f][(br-2+r)*W + (bc-2+c)];
        m.mask[j] = 1'b1;
      end
    end
    m.last = (b == NBUN - 1);
    return m;
  endfunction

  function automatic logic [WW-1:0] pack_list(input int v [9]);
    logic [WW-1:0] p = '0;
    for (int k = 0; k < 9; k++) p[k*EW +: EW] = EW'(v[k]);
    return p;
  endfunction

  // Ramp-frame window whose top-left pixel is (tr,tc); pixel value = row*W+col.
  function automatic logic [WW-1:0] ramp_win(int tr, int tc);
    logic [WW-1:0] p = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[(r*3+c)*EW +: EW] = EW'((tr + r) * W + (tc + c));
    return p;
  endfunction

  function automatic bundle_t dut_bundle();
    bundle_t d;
    d.data = ifmap_chunk_o;
    d.mask = win_mask_o;
    d.last = win_last_o;
    return d;
  endfunction

  function automatic string bundle_msg(bundle_t got, bundle_t exp);
    int lane = -1;
    for (int j = NM - 1; j >= 0; j--) if (got.data[j] !== exp.data[j]) lane = j;
    if (lane < 0) lane = 0;
    return $sformatf("mask %h want %h last %b want %b lane%0d %h want %h",
                     got.mask, exp.mask, got.last, exp.last, lane,
                     got.data[lane], exp.data[lane]);
  endfunction

  // Called at a negedge; returns at the negedge right after the pixel is taken.
  task automatic send_px(input logic [EW-1:0] v);
    int guard = 0;
    px_i       = v;
    px_valid_i = 1'b1;
    while (px_ready_o !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL send_px_timeout: pixel %0d not accepted within 200 cycles", v);
        break;
      end
    end
    @(negedge clk);
    px_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (px_ready_o !== 1'b1 || win_valid_o !== 1'b0 || win_last_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: ready %b valid %b last %b want 1 0 0", tag,
               px_ready_o, win_valid_o, win_last_o);
    end
    checks++;
    if (win_mask_o !== '0) begin
      errors++;
      $display("FAIL %s_mask: got %h want 0", tag, win_mask_o);
    end
    checks++;
    if (ifmap_chunk_o !== '0) begin
      errors++;
      $display("FAIL %s_chunk: lane0 %h lane15 %h want all zero", tag,
               ifmap_chunk_o[0], ifmap_chunk_o[NM-1]);
    end
  endtask

  task automatic apply_reset();
    px_valid_i  = 1'b0;
    win_ready_i = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Full ramp frame with win_ready_i tied high; returns back in FILL.
  task automatic run_ramp(input string tag);
    int unsigned t0;
    int          b = 0;
    logic        exp_valid;
    bundle_t     got;
    bundle_t     exp;
    for (int i = 0; i < NPIX; i++) frames[0][i] = EW'(i);
    win_ready_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < NPIX; i++) begin
      send_px(EW'(i));
      exp_valid = (i == 37 || i == 59 || i == 63);
      checks++;
      if (win_valid_o !== exp_valid) begin
        errors++;
        $display("FAIL %s_valid_after_px%0d: got %b want %b", tag, i, win_valid_o, exp_valid);
      end
      if (exp_valid) begin
        got = dut_bundle();
        exp = model_bundle(0, b);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s_bundle%0d: %s", tag, b + 1, bundle_msg(got, exp));
        end
        b++;
      end
      if (i == 37) begin
        checks++;
        if (win_mask_o !== 16'hFFFF || ifmap_chunk_o[0] !== pack_list(lane0_ref)) begin
          errors++;
          $display("FAIL %s_b1_lane0: mask %h lane0 %h want FFFF %h", tag, win_mask_o,
                   ifmap_chunk_o[0], pack_list(lane0_ref));
        end
      end
      if (i == 59) begin
        checks++;
        if (ifmap_chunk_o[15] !== ramp_win(5, 1)) begin
          errors++;
          $display("FAIL %s_b2_lane15: got %h want %h", tag, ifmap_chunk_o[15], ramp_win(5, 1));
        end
      end
      if (i == 63) begin
        checks++;
        if (win_mask_o !== 16'h000F || win_last_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_final_mask_last: mask %h last %b want 000F 1", tag,
                   win_mask_o, win_last_o);
        end
        checks++;
        if (ifmap_chunk_o[NM-1:4] !== '0) begin
          errors++;
          $display("FAIL %s_final_unused_lanes: lane4 %h lane15 %h want zero", tag,
                   ifmap_chunk_o[4], ifmap_chunk_o[15]);
        end
        checks++;
        if (ifmap_chunk_o[3] !== pack_list(lane3_ref)) begin
          errors++;
          $display("FAIL %s_final_lane3: got %h want %h", tag, ifmap_chunk_o[3],
                   pack_list(lane3_ref));
        end
      end
    end
    // 64 pixels plus one stall for each of the two full bundles
    checks++;
    if (cyc - t0 != 66) begin
      errors++;
      $display("FAIL %s_throughput: %0d cycles want 66", tag, cyc - t0);
    end
    @(negedge clk);
    checks++;
    if (px_ready_o !== 1'b1 || win_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_final: ready %b valid %b want 1 0", tag, px_ready_o, win_valid_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp_frame();
    run_ramp("ramp");
  endtask

  task automatic test_backpressure();
    bundle_t held;
    bundle_t got;
    bundle_t exp;
    for (int i = 0; i < NPIX; i++) frames[0][i] = EW'(i);
    win_ready_i = 1'b1;
    for (int i = 0; i < 37; i++) send_px(EW'(i));
    win_ready_i = 1'b0;
    send_px(EW'(37));
    held = dut_bundle();
    exp  = model_bundle(0, 0);
    checks++;
    if (held !== exp) begin
      errors++;
      $display("FAIL bp_bundle1: %s", bundle_msg(held, exp));
    end
    px_i       = EW'(38);
    px_valid_i = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      checks++;
      if (win_valid_o !== 1'b1 || px_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_ctrl_t%0d: valid %b ready %b want 1 0", t, win_valid_o, px_ready_o);
      end
      got = dut_bundle();
      checks++;
      if (got !== held) begin
        errors++;
        $display("FAIL bp_hold_stable_t%0d: %s", t, bundle_msg(got, held));
      end
    end
    win_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (win_valid_o !== 1'b0 || px_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_transfer: valid %b ready %b want 0 1", win_valid_o, px_ready_o);
    end
    for (int i = 38; i < NPIX; i++) begin
      send_px(EW'(i));
      if (i == 59 || i == 63) begin
        got = dut_bundle();
        exp = model_bundle(0, (i == 59) ? 1 : 2);
        checks++;
        if (win_valid_o !== 1'b1 || got !== exp) begin
          errors++;
          $display("FAIL bp_after_px%0d: valid %b %s", i, win_valid_o, bundle_msg(got, exp));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    win_ready_i = 1'b1;
    for (int i = 0; i < 59; i++) send_px(EW'(i));
    win_ready_i = 1'b0;
    send_px(EW'(59));
    @(negedge clk);
    checks++;
    if (win_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_setup: valid %b want 1", win_valid_o);
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid_hold");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_ramp("post_rst");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NPIX; p++) frames[f][p] = EW'($urandom);
    win_ready_i = 1'b0;
    fork
      begin
        for (int f = 0; f < 2; f++)
          for (int p = 0; p < NPIX; p++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_px(frames[f][p]);
          end
      end
      begin
        int      k = 0;
        int      budget = 0;
        logic    holding = 1'b0;
        bundle_t held;
        bundle_t got;
        bundle_t exp;
        while (k < 2 * NBUN && budget < 3000) begin
          @(negedge clk);
          budget++;
          if (win_valid_o === 1'b1) begin
            got = dut_bundle();
            checks++;
            if (px_ready_o !== 1'b0) begin
              errors++;
              $display("FAIL rand_ready_in_hold: got %b want 0", px_ready_o);
            end
            if (holding) begin
              checks++;
              if (got !== held) begin
                errors++;
                $display("FAIL rand_hold_stable: %s", bundle_msg(got, held));
              end
            end
            held    = got;
            holding = 1'b1;
          end else begin
            holding = 1'b0;
          end
          win_ready_i = ($urandom_range(0, 2) != 0);
          if (win_valid_o === 1'b1 && win_ready_i) begin
            exp = model_bundle(k / NBUN, k % NBUN);
            checks++;
            if (got !== exp) begin
              errors++;
              $display("FAIL rand_f%0d_b%0d: %s", k / NBUN, k % NBUN, bundle_msg(got, exp));
            end
            k++;
            holding = 1'b0;
          end
        end
        if (k < 2 * NBUN) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout: %0d bundles seen want %0d", k, 2 * NBUN);
        end
      end
    join
    win_ready_i = 1'b1;
    @(negedge clk);
  endtask

`ifdef WINGEN_STATS_EN
  task automatic test_stats();
    apply_reset();
    checks++;
    if (bundle_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d want 0", bundle_cnt_o);
    end
    run_ramp("stats_f1");
    checks++;
    if (bundle_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL stats_frame1: got %0d want 3", bundle_cnt_o);
    end
    run_ramp("stats_f2");
    checks++;
    if (bundle_cnt_o !== 16'd6) begin
      errors++;
      $display("FAIL stats_frame2: got %0d want 6", bundle_cnt_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp_frame();
    test_backpressure();
    test_reset_mid_hold();
    test_random_frames();
`ifdef WINGEN_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
